hamming_router_tx: RTL and testbench
====================================

Name: hamming_router_tx

Overview:
Parametrised successor of the fixed 4-port Hamming router. Each accepted 4-bit message is Hamming(7,4) encoded, with an optional extended-parity bit. The codeword is routed to one of NUM_CH serial transmit lanes selected by in_sel. Each lane then shifts its frame out on data_line with a strobe. Unlike the fixed router, input uses a valid/ready handshake with per-lane backpressure and a configurable inter-frame gap, so no frame is ever overwritten mid-transmission.

Parameters:
NUM_CH, 4, number of output lanes; power of 2, 2..16; SEL_W = clog2(NUM_CH) is derived, not overridable.
EXT_PARITY, 0, 1 appends overall-parity bit 8 (SECDED frame); CODE_W = 7 + EXT_PARITY.
GAP, 1, idle cycles forced on a lane between frames, 0..15; 0 allows back-to-back frames.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  message present
in_ready  out  1  lane addressed by in_sel can accept this cycle (combinational from in_sel and lane state)
in_sel  in  SEL_W  destination lane
in_msg  in  4  message; in_msg[3]=d1 … in_msg[0]=d4
data_line  out  NUM_CH  serial data per lane
strobe  out  NUM_CH  high while the lane's data_line carries a frame bit
busy  out  NUM_CH  lane transmitting or in gap

Behaviour:
- Reset (rst=0, async): all lanes IDLE; data_line=0, strobe=0, busy=0; shift registers and counters cleared. A frame in flight is aborted immediately; no further strobe from it.
- Encoding: p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4. Codeword positions 1..7 = p1,p2,d1,p4,d2,d3,d4. If EXT_PARITY=1, position 8 = XOR of positions 1..7.
- Accept: transfer occurs on a rising edge with in_valid & in_ready. Only lane in_sel loads. Other lanes are unaffected.
- in_ready = 1 when lane in_sel is IDLE. When GAP=0 it is also 1 when the lane is in SHIFT on its last bit.
- Lane FSM: IDLE -> SHIFT on accept.
  - SHIFT lasts CODE_W cycles; position 1 is sent first.
  - From the last bit, the lane goes to GAP_WAIT if GAP>0, to SHIFT with a new frame if GAP=0 and an accept occurs, else to IDLE.
  - GAP_WAIT lasts exactly GAP cycles, then IDLE.
- Latency: accept at edge T → position 1 on data_line and strobe=1 during cycle T+1. The last bit is in cycle T+CODE_W. strobe=0 at T+CODE_W+1 unless a GAP=0 back-to-back frame starts.
- busy = 1 in SHIFT and GAP_WAIT, 0 in IDLE. data_line = 0 whenever strobe = 0.
- in_valid while in_ready=0: no effect. The source must hold in_msg and in_sel stable until accepted; in_sel may change while waiting (in_ready re-evaluates).
- Concurrency: lanes are independent. One accept per cycle, but all NUM_CH lanes may shift simultaneously.
- Counters: the bit counter is clog2(CODE_W+1) wide and the gap counter is 4 bits; neither can wrap within a frame.

Decomposition:
- Package hamming_router_pkg: hamming74_encode function, ext_parity function, lane state encoding (IDLE, SHIFT, GAP_WAIT), CODE_W localparam rule.
- Sub-module hamming_tx_lane: one instance per lane via generate.
  - Inputs: load, code, CODE_W, GAP.
  - Outputs: data_line, strobe, busy, can_load.
- The top contains only the encoder, the in_sel decode and the in_ready mux.

Test Plan:
- Reset mid-frame: drive rst=0 during bit 3 of a lane-1 frame → data_line, strobe and busy all 0 immediately; no strobe on any lane after rst returns to 1.
- Basic encode, lane 2, EXT_PARITY=0: accept in_msg=4'b1011, in_sel=2 at edge T → lane 2 sends 0,1,1,0,0,1,1 in cycles T+1..T+7 with strobe=1; other lanes stay 0.
- Extended parity, EXT_PARITY=1: in_msg=4'b1000 → frame 1,1,1,0,0,0,0,1 over 8 cycles. in_msg=4'b0001 → frame 1,1,0,1,0,0,1,0.
- Backpressure, GAP=2: accept on lane 0, hold in_valid with in_sel=0 → in_ready=0 for 9 cycles (7 SHIFT + 2 GAP_WAIT); the second frame starts exactly at cycle T+10.
- Back-to-back, GAP=0: two consecutive accepts on lane 3 (4'b0001 then 4'b1011) → strobe stays high for 14 contiguous cycles with frame bits 1101001 then 0110011.
- Parallel lanes, NUM_CH=8: accept on lanes 5, 6 and 7 in consecutive cycles → three overlapping frames, each offset by 1 cycle; in_ready to a busy lane stays 0 while idle lanes still accept.

Source files
------------

// File: rtl/hamming_router_pkg.sv
// Shared definitions for the parametrised Hamming(7,4) transmit router.
//
// Contents:
//   lane_state_e     - per-lane transmit FSM encoding (IDLE, SHIFT, GAP_WAIT)
//   code_width()     - frame length rule: 7 bits, plus 1 when extended parity is on
//   hamming74_encode - 4-bit message to 7-bit codeword; bit 0 is position 1
//   ext_parity()     - overall parity over positions 1..7 (SECDED bit 8)
package hamming_router_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    GAP_WAIT = 2'd2
  } lane_state_e;

  function automatic int code_width(input int ext_parity_en);
    return 7 + ext_parity_en;
  endfunction

  // msg[3]=d1 .. msg[0]=d4. Result is stored LSB-first in transmit order,
  // so bit 0 (position 1) is the first bit put on the line.
  function automatic logic [6:0] hamming74_encode(input logic [3:0] msg);
    logic d1, d2, d3, d4;
    logic p1, p2, p4;
    d1 = msg[3];
    d2 = msg[2];
    d3 = msg[1];
    d4 = msg[0];
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p4 = d2 ^ d3 ^ d4;
    return {d4, d3, d2, p4, d1, p2, p1};
  endfunction

  function automatic logic ext_parity(input logic [6:0] code);
    return ^code;
  endfunction

endpackage

// File: rtl/hamming_tx_lane.sv
// One serial transmit lane of the Hamming router.
//
// Parameters:
//   CODE_W - frame length in bits (7 or 8)
//   GAP    - idle cycles forced after each frame (0..15)
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset; aborts any frame in flight
//   load      - accept code this cycle (only honoured while can_load is high)
//   code      - frame to send, bit 0 first
//   data_line - serial frame bit, 0 whenever strobe is low
//   strobe    - high while data_line carries a frame bit
//   busy      - lane is shifting or in its inter-frame gap
//   can_load  - lane can take a new frame on the next edge
module hamming_tx_lane
  import hamming_router_pkg::*;
#(
  parameter int CODE_W = 7,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CODE_W-1:0] code,
  output logic              data_line,
  output logic              strobe,
  output logic              busy,
  output logic              can_load
);

  localparam int CNT_W = $clog2(CODE_W + 1);

  lane_state_e       state;
  logic [CODE_W-2:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [3:0]        gap_cnt;
  logic              last_bit;

  // bit_cnt counts the bits still to come after the one on the line now,
  // so zero in SHIFT means the final frame bit is being driven.
  assign last_bit = (state == SHIFT) && (bit_cnt == '0);

  // With no gap the lane may chain a new frame directly after its last bit.
  assign can_load = (state == IDLE) || ((GAP == 0) && last_bit);
  assign busy     = (state != IDLE);

  // Lane FSM. Position 1 is registered onto data_line at the accepting edge;
  // the remaining bits sit in shreg and move out one per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      data_line <= 1'b0;
      strobe    <= 1'b0;
    end else if (load && can_load) begin
      state     <= SHIFT;
      data_line <= code[0];
      strobe    <= 1'b1;
      shreg     <= code[CODE_W-1:1];
      bit_cnt   <= CNT_W'(CODE_W - 1);
    end else begin
      case (state)
        SHIFT: begin
          if (bit_cnt != '0) begin
            data_line <= shreg[0];
            shreg     <= shreg >> 1;
            bit_cnt   <= bit_cnt - CNT_W'(1);
          end else begin
            data_line <= 1'b0;
            strobe    <= 1'b0;
            if (GAP > 0) begin
              state   <= GAP_WAIT;
              gap_cnt <= 4'(GAP - 1);
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP_WAIT: begin
          if (gap_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/hamming_router_tx.sv
// Parametrised Hamming(7,4) transmit router with valid/ready input.
//
// Each accepted 4-bit message is encoded (optionally with SECDED parity)
// and handed to lane in_sel, which shifts the frame out serially.
//
// Parameters:
//   NUM_CH     - number of lanes, power of 2 in 2..16
//   EXT_PARITY - 1 appends overall parity as frame bit 8
//   GAP        - idle cycles forced on a lane between frames (0..15)
// Ports:
//   clk, rst   - clock and asynchronous active-low reset
//   in_valid   - message present
//   in_ready   - lane in_sel can accept this cycle
//   in_sel     - destination lane
//   in_msg     - message, in_msg[3]=d1 .. in_msg[0]=d4
//   data_line  - serial data per lane
//   strobe     - per-lane frame bit qualifier
//   busy       - per-lane transmitting or in gap
module hamming_router_tx
  import hamming_router_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int EXT_PARITY = 0,
  parameter  int GAP        = 1,
  localparam int SEL_W      = $clog2(NUM_CH),
  localparam int CODE_W     = code_width(EXT_PARITY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [3:0]        in_msg,
  output logic [NUM_CH-1:0] data_line,
  output logic [NUM_CH-1:0] strobe,
  output logic [NUM_CH-1:0] busy
);

  logic [6:0]        code7;
  logic [CODE_W-1:0] code;
  logic [NUM_CH-1:0] can_load;
  logic [NUM_CH-1:0] load;

  assign code7 = hamming74_encode(in_msg);

  if (EXT_PARITY != 0) begin : g_secded
    assign code = {ext_parity(code7), code7};
  end else begin : g_plain
    assign code = code7;
  end

  assign in_ready = can_load[in_sel];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign load[i] = in_valid && in_ready && (in_sel == SEL_W'(i));

    hamming_tx_lane #(
      .CODE_W (CODE_W),
      .GAP    (GAP)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .code      (code),
      .data_line (data_line[i]),
      .strobe    (strobe[i]),
      .busy      (busy[i]),
      .can_load  (can_load[i])
    );
  end

endmodule

// File: tb/tb_hamming_router_tx.sv
// Self-checking bench for hamming_router_tx.
//
// Three configurations run side by side on one clock/reset:
//   k0: NUM_CH=4, EXT_PARITY=1, GAP=1
//   k1: NUM_CH=4, EXT_PARITY=0, GAP=0
//   k2: NUM_CH=8, EXT_PARITY=0, GAP=2
// Accepted frames are pushed as time-stamped bits into a per-lane queue and
// popped by a monitor that samples every falling edge.
module tb_hamming_router_tx;

  localparam int NCFG = 3;

  function automatic int nc_of(input int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic int ext_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int gap_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic                       in_valid_v [NCFG];
  logic [3:0]                 in_sel_v   [NCFG];
  logic [3:0]                 in_msg_v   [NCFG];
  logic [NCFG-1:0]            in_ready_v;
  logic [NCFG-1:0][7:0]       data_v;
  logic [NCFG-1:0][7:0]       strobe_v;
  logic [NCFG-1:0][7:0]       busy_v;

  for (genvar k = 0; k < NCFG; k++) begin : g_dut
    localparam int NC = nc_of(k);
    localparam int SW = $clog2(NC);

    hamming_router_tx #(
      .NUM_CH     (NC),
      .EXT_PARITY (ext_of(k)),
      .GAP        (gap_of(k))
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[k]),
      .in_ready  (in_ready_v[k]),
      .in_sel    (in_sel_v[k][SW-1:0]),
      .in_msg    (in_msg_v[k]),
      .data_line (data_v[k][NC-1:0]),
      .strobe    (strobe_v[k][NC-1:0]),
      .busy      (busy_v[k][NC-1:0])
    );

    if (NC < 8) begin : g_pad
      assign data_v[k][7:NC]   = '0;
      assign strobe_v[k][7:NC] = '0;
      assign busy_v[k][7:NC]   = '0;
    end
  end

  always #5 clk = ~clk;

  // Number of rising edges seen; a frame accepted at edge A shows its bits
  // while cyc = A .. A+CODE_W-1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic b;
  } exp_t;

  exp_t expq   [NCFG*8][$];
  int   bstart [NCFG*8];
  int   bend   [NCFG*8];

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_ready(input int k, input int lane, input int c);
    int  idx;
    bit  bsy;
    idx = k*8 + lane;
    bsy = (c >= bstart[idx]) && (c <= bend[idx]);
    return !bsy || ((gap_of(k) == 0) && (c == bend[idx]));
  endfunction

  // Frame in transmit order, MSB = position 1.
  function automatic logic [7:0] ref_frame(input int k, input logic [3:0] m);
    logic [6:0] s;
    logic p1, p2, p4;
    p1 = m[3] ^ m[2] ^ m[0];
    p2 = m[3] ^ m[1] ^ m[0];
    p4 = m[2] ^ m[1] ^ m[0];
    s  = {p1, p2, m[3], p4, m[2], m[1], m[0]};
    if (ext_of(k) != 0) return {s, ^s};
    return {1'b0, s};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NCFG*8; i++) begin
      expq[i].delete();
      bstart[i] = -10;
      bend[i]   = -20;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Called just after a falling edge. Holds the request until the lane is
  // free, then records the expected frame for the accepting edge.
  task automatic applyStimulus(input int k, input int sel, input logic [3:0] msg,
                               input logic [7:0] frame, output int waited);
    int   a;
    int   cw;
    exp_t e;
    in_sel_v[k]   = 4'(sel);
    in_msg_v[k]   = msg;
    in_valid_v[k] = 1'b1;
    waited = 0;
    while (!model_ready(k, sel, cyc) && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!model_ready(k, sel, cyc)) begin
      checkOutput($sformatf("accept timeout k%0d l%0d", k, sel), 32'd0, 32'd1);
    end else begin
      a  = cyc + 1;
      cw = 7 + ext_of(k);
      for (int j = 0; j < cw; j++) begin
        e.c = a + j;
        e.b = frame[cw-1-j];
        expq[k*8 + sel].push_back(e);
      end
      bstart[k*8 + sel] = a;
      bend[k*8 + sel]   = a + cw + gap_of(k) - 1;
    end
    @(negedge clk);
    #1;
    in_valid_v[k] = 1'b0;
  endtask

  // Scoreboard monitor: strobe/data timing, busy window and in_ready.
  logic mon_es;
  int   mon_idx;
  always @(negedge clk) begin
    for (int k = 0; k < NCFG; k++) begin
      for (int l = 0; l < nc_of(k); l++) begin
        mon_idx = k*8 + l;
        mon_es  = (expq[mon_idx].size() > 0) && (expq[mon_idx][0].c == cyc);
        checkOutput($sformatf("strobe k%0d l%0d", k, l), 32'(strobe_v[k][l]), 32'(mon_es));
        if (mon_es) begin
          checkOutput($sformatf("data k%0d l%0d", k, l), 32'(data_v[k][l]), 32'(expq[mon_idx][0].b));
          void'(expq[mon_idx].pop_front());
        end else begin
          checkOutput($sformatf("data idle k%0d l%0d", k, l), 32'(data_v[k][l]), 32'd0);
        end
        checkOutput($sformatf("busy k%0d l%0d", k, l), 32'(busy_v[k][l]),
                    32'((cyc >= bstart[mon_idx]) && (cyc <= bend[mon_idx])));
      end
      checkOutput($sformatf("in_ready k%0d", k), 32'(in_ready_v[k]),
                  32'(model_ready(k, int'(in_sel_v[k]), cyc)));
    end
  end

  int w;
  int w2;

  initial begin
    clear_model();
    for (int k = 0; k < NCFG; k++) begin
      in_valid_v[k] = 1'b0;
      in_sel_v[k]   = '0;
      in_msg_v[k]   = '0;
    end
    rst = 1'b0;
    idle(3);
    checkOutput("reset strobe", 32'(strobe_v), 32'd0);
    checkOutput("reset busy", 32'(busy_v), 32'd0);
    rst = 1'b1;
    idle(2);

    // Basic encode on lane 2 without extended parity.
    applyStimulus(2, 2, 4'b1011, 8'b0_0110011, w);
    applyStimulus(1, 2, 4'b1011, 8'b0_0110011, w);
    idle(2);

    // Extended parity frames.
    applyStimulus(0, 0, 4'b1000, 8'b11100001, w);
    applyStimulus(0, 1, 4'b0001, 8'b11010010, w);
    idle(12);

    // Backpressure with GAP=2: 7 shift + 2 gap cycles of in_ready low.
    applyStimulus(2, 0, 4'b0110, ref_frame(2, 4'b0110), w);
    applyStimulus(2, 0, 4'b1110, ref_frame(2, 4'b1110), w);
    checkOutput("backpressure wait", 32'(w), 32'd9);
    idle(12);

    // Back-to-back with GAP=0: second frame accepted on the first's last bit.
    applyStimulus(1, 3, 4'b0001, 8'b0_1101001, w);
    applyStimulus(1, 3, 4'b1011, 8'b0_0110011, w);
    checkOutput("b2b wait", 32'(w), 32'd6);
    idle(10);

    // Parallel lanes on the 8-lane instance.
    applyStimulus(2, 5, 4'b0011, ref_frame(2, 4'b0011), w);
    checkOutput("par lane5 wait", 32'(w), 32'd0);
    applyStimulus(2, 6, 4'b0101, ref_frame(2, 4'b0101), w);
    checkOutput("par lane6 wait", 32'(w), 32'd0);
    applyStimulus(2, 7, 4'b1111, ref_frame(2, 4'b1111), w);
    checkOutput("par lane7 wait", 32'(w), 32'd0);
    in_sel_v[2]   = 4'd5;
    in_msg_v[2]   = 4'b1001;
    in_valid_v[2] = 1'b1;
    #1;
    checkOutput("busy lane5 ready", 32'(in_ready_v[2]), 32'd0);
    idle(1);
    applyStimulus(2, 4, 4'b1001, ref_frame(2, 4'b1001), w2);
    checkOutput("idle lane4 wait", 32'(w2), 32'd0);
    idle(15);

    // Reset in the middle of a lane-1 frame (bit 3 on the line).
    applyStimulus(2, 1, 4'b1101, ref_frame(2, 4'b1101), w);
    idle(2);
    rst = 1'b0;
    clear_model();
    #1;
    checkOutput("midrst strobe", 32'(strobe_v), 32'd0);
    checkOutput("midrst data", 32'(data_v), 32'd0);
    checkOutput("midrst busy", 32'(busy_v), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(12);

    // Random traffic on every configuration.
    for (int k = 0; k < NCFG; k++) begin
      for (int n = 0; n < 14; n++) begin
        int          lane;
        logic [3:0]  m;
        lane = int'($urandom_range(nc_of(k) - 1, 0));
        m    = 4'($urandom_range(15, 0));
        applyStimulus(k, lane, m, ref_frame(k, m), w);
        idle(int'($urandom_range(2, 0)));
      end
    end
    idle(30);

    for (int i = 0; i < NCFG*8; i++) begin
      checkOutput($sformatf("drain q%0d", i), 32'(expq[i].size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
